// File: rtl/morph_program_sequencer.sv
// morph_program_sequencer
//   Stores a short program of morphological/logic instruction words and,
//   on start, clears the morphologic processor (MP) for one cycle. It then
//   issues one instruction per cycle with proc_ce and ends with a one-cycle
//   done pulse.
//   Instruction word: {logic_op[15:13], morph_in_sel[12], morph_op[11:9], el[8:0]}.
//   Optional feature: define MORPH_SEQ_ZERO_EXIT_EN to end a run early when
//   the MP accumulator reports zero (acc_zero). The run then reports early_exit.
module morph_program_sequencer #(
  parameter int ProgDepth  = 8,
  parameter int AddrWidth  = 3,
  parameter int InstrWidth = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  prog_we,
  input  logic [AddrWidth-1:0]  prog_addr,
  input  logic [InstrWidth-1:0] prog_wdata,
  input  logic [AddrWidth:0]    prog_len,
  input  logic                  acc_zero,
  output logic                  busy,
  output logic                  done,
  output logic                  early_exit,
  output logic                  proc_clr,
  output logic                  proc_ce,
  output logic [8:0]            el,
  output logic [2:0]            morph_op,
  output logic                  morph_in_sel,
  output logic [2:0]            logic_op,
  output logic [AddrWidth:0]    pc
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [AddrWidth:0] Depth = (AddrWidth + 1)'(ProgDepth);

  state_t                  state;
  logic [AddrWidth:0]      len_q;
  logic [InstrWidth-1:0]   mem [ProgDepth];
  logic [InstrWidth-1:0]   rd_word;
  logic                    zero_exit;

  // The word at pc is the next one to issue; pc never indexes past len_q.
  assign rd_word = mem[pc[AddrWidth-1:0]];

`ifdef MORPH_SEQ_ZERO_EXIT_EN
  // Stop once at least one instruction has run and the accumulator is empty.
  assign zero_exit = acc_zero && (pc != '0);
`else
  logic unused_acc_zero;
  assign unused_acc_zero = acc_zero;
  assign zero_exit       = 1'b0;
`endif

  // Program store: host writes land only while idle, so a running program
  // can never be modified under itself.
  // NOTE: the instruction RAM has no reset; clearing it would turn the array
  // into flops and add nothing, because the host always loads it before a run.
  always_ff @(posedge clk) begin
    if (prog_we && (state == S_IDLE)) begin
      mem[prog_addr] <= prog_wdata;
    end
  end

  // Sequencer FSM with registered outputs; strobes and instruction fields
  // default low so they are 0 in every cycle that does not issue.
  // NOTE: every register here uses <=, so all branches see the pre-edge
  // values of pc/len_q/state regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      len_q        <= '0;
      pc           <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      early_exit   <= 1'b0;
      proc_clr     <= 1'b0;
      proc_ce      <= 1'b0;
      el           <= '0;
      morph_op     <= '0;
      morph_in_sel <= 1'b0;
      logic_op     <= '0;
    end else begin
      done         <= 1'b0;
      proc_clr     <= 1'b0;
      proc_ce      <= 1'b0;
      el           <= '0;
      morph_op     <= '0;
      morph_in_sel <= 1'b0;
      logic_op     <= '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q      <= (prog_len > Depth) ? Depth : prog_len;
            pc         <= '0;
            early_exit <= 1'b0;
            proc_clr   <= 1'b1;
            busy       <= 1'b1;
            state      <= S_CLEAR;
          end
        end
        S_CLEAR, S_RUN: begin
          if (abort) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else if ((state == S_RUN) && zero_exit) begin
            busy       <= 1'b0;
            done       <= 1'b1;
            early_exit <= 1'b1;
            state      <= S_DONE;
          end else if (pc == len_q) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            proc_ce      <= 1'b1;
            logic_op     <= rd_word[15:13];
            morph_in_sel <= rd_word[12];
            morph_op     <= rd_word[11:9];
            el           <= rd_word[8:0];
            pc           <= pc + 1'b1;
            state        <= S_RUN;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morph_program_sequencer.sv
// tb_morph_program_sequencer
//   Table of directed runs plus randomized runs. Each run is checked cycle by
//   cycle against a timeline derived from the program length, abort and
//   acc_zero cycles, and a shadow copy of the program store.
module tb_morph_program_sequencer;

`ifdef MORPH_SEQ_ZERO_EXIT_EN
  localparam bit ZeroExit = 1'b1;
`else
  localparam bit ZeroExit = 1'b0;
`endif

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       early_exit;
    logic       proc_clr;
    logic       proc_ce;
    logic [8:0] el;
    logic [2:0] morph_op;
    logic       morph_in_sel;
    logic [2:0] logic_op;
    logic [3:0] pc;
  } out_t;

  typedef struct {
    string       name;
    int          len;
    int          abort_cyc;
    int          az_cyc;
    int          we_cyc;
    int          we_addr;
    logic [15:0] we_data;
    int          exp_issued;
    int          exp_early;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        prog_we;
  logic [2:0]  prog_addr;
  logic [15:0] prog_wdata;
  logic [3:0]  prog_len;
  logic        acc_zero;
  logic        busy, done, early_exit, proc_clr, proc_ce;
  logic [8:0]  el;
  logic [2:0]  morph_op;
  logic        morph_in_sel;
  logic [2:0]  logic_op;
  logic [3:0]  pc;

  out_t        act;
  logic [15:0] ref_mem [8];
  int          vectors    = 0;
  int          miscompares = 0;
  vec_t        vecs [12];

  assign act = {busy, done, early_exit, proc_clr, proc_ce, el, morph_op,
                morph_in_sel, logic_op, pc};

  always #5 clk = ~clk;

  morph_program_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_wdata   (prog_wdata),
    .prog_len     (prog_len),
    .acc_zero     (acc_zero),
    .busy         (busy),
    .done         (done),
    .early_exit   (early_exit),
    .proc_clr     (proc_clr),
    .proc_ce      (proc_ce),
    .el           (el),
    .morph_op     (morph_op),
    .morph_in_sel (morph_in_sel),
    .logic_op     (logic_op),
    .pc           (pc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int k, input logic [31:0] got,
                       input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, k, got, want);
    end
  endtask

  // Expected outputs in cycle k after start (cycle 1 = clear), for a run
  // that issues m instructions and ends with early-exit flag e.
  function automatic out_t expect_at(int k, int m, bit e);
    out_t        x;
    logic [15:0] w;
    x = '0;
    if (k == 1) begin
      x.busy     = 1'b1;
      x.proc_clr = 1'b1;
    end else if (k <= m + 1) begin
      w              = ref_mem[k-2];
      x.busy         = 1'b1;
      x.proc_ce      = 1'b1;
      x.logic_op     = w[15:13];
      x.morph_in_sel = w[12];
      x.morph_op     = w[11:9];
      x.el           = w[8:0];
      x.pc           = 4'(k - 1);
    end else begin
      x.done       = (k == m + 2);
      x.pc         = 4'(m);
      x.early_exit = e;
    end
    return x;
  endfunction

  task automatic write_slot(input int addr, input logic [15:0] data);
    prog_we    = 1'b1;
    prog_addr  = 3'(addr);
    prog_wdata = data;
    step();
    prog_we       = 1'b0;
    ref_mem[addr] = data;
  endtask

  // One complete run from IDLE. abort/acc_zero/prog_we are each held high
  // for the single cycle number given (0 = start cycle for prog_we, -1/0 = none).
  task automatic run_vec(input string name, input int len, input int abort_cyc,
                         input int az_cyc, input int we_cyc, input int we_addr,
                         input logic [15:0] we_data, input int exp_issued,
                         input int exp_early);
    int n;
    int m;
    int ce_seen;
    bit e;
    if (we_cyc == 0) begin
      prog_we          = 1'b1;
      prog_addr        = 3'(we_addr);
      prog_wdata       = we_data;
      ref_mem[we_addr] = we_data;
    end
    start    = 1'b1;
    prog_len = 4'(len);
    step();
    start   = 1'b0;
    prog_we = 1'b0;
    n = (len > 8) ? 8 : len;
    m = n;
    e = 1'b0;
    if (ZeroExit && az_cyc >= 2 && az_cyc <= n + 1) begin
      m = az_cyc - 1;
      e = 1'b1;
    end
    if (abort_cyc >= 1 && abort_cyc <= n + 1 && abort_cyc - 1 <= m) begin
      m = abort_cyc - 1;
      e = 1'b0;
    end
    ce_seen = 0;
    for (int k = 1; k <= m + 3; k++) begin
      check(name, k, 32'(act), 32'(expect_at(k, m, e)));
      ce_seen += int'(act.proc_ce);
      abort    = (k == abort_cyc);
      acc_zero = (k == az_cyc);
      if (k == we_cyc) begin
        prog_we    = 1'b1;
        prog_addr  = 3'(we_addr);
        prog_wdata = we_data;
      end else begin
        prog_we = 1'b0;
      end
      step();
    end
    abort    = 1'b0;
    acc_zero = 1'b0;
    prog_we  = 1'b0;
    if (we_cyc == m + 3) ref_mem[we_addr] = we_data;
    if (exp_issued >= 0) check({name, "/issued"}, 0, 32'(ce_seen), 32'(exp_issued));
    if (exp_early >= 0) check({name, "/early"}, 0, 32'(act.early_exit), 32'(exp_early));
  endtask

  initial begin
    vecs[0]  = '{"prog3",         3, 0, 0, -1, 0, 16'h0000, 3, 0};
    vecs[1]  = '{"len0",          0, 0, 0, -1, 0, 16'h0000, 0, 0};
    vecs[2]  = '{"len9_sat",      9, 0, 0, -1, 0, 16'h0000, 8, 0};
    vecs[3]  = '{"len15_sat",    15, 0, 0, -1, 0, 16'h0000, 8, 0};
    vecs[4]  = '{"abort_run",     6, 4, 0, -1, 0, 16'h0000, 3, 0};
    vecs[5]  = '{"abort_clear",   6, 1, 0, -1, 0, 16'h0000, 0, 0};
    vecs[6]  = '{"abort_done",    2, 4, 0, -1, 0, 16'h0000, 2, 0};
    vecs[7]  = '{"zero_exit",     5, 0, 3, -1, 0, 16'h0000,
                 ZeroExit ? 2 : 5, ZeroExit ? 1 : 0};
    vecs[8]  = '{"we_busy",       3, 0, 0,  2, 1, 16'hBEEF, 3, 0};
    vecs[9]  = '{"after_we_busy", 3, 0, 0, -1, 0, 16'h0000, 3, 0};
    vecs[10] = '{"we_with_start", 3, 0, 0,  0, 1, 16'h1234, 3, 0};
    vecs[11] = '{"len1",          1, 0, 0, -1, 0, 16'h0000, 1, 0};

    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    prog_we    = 1'b0;
    prog_addr  = '0;
    prog_wdata = '0;
    prog_len   = '0;
    acc_zero   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 0, 32'(act), 32'(0));
    rst = 1'b0;
    step();

    write_slot(0, 16'h2010);
    write_slot(1, 16'h4A55);
    write_slot(2, 16'hE1FF);
    write_slot(3, 16'h1F3C);
    write_slot(4, 16'h8001);
    write_slot(5, 16'h7ABC);
    write_slot(6, 16'hC0DE);
    write_slot(7, 16'h5AA5);

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i].name, vecs[i].len, vecs[i].abort_cyc, vecs[i].az_cyc,
              vecs[i].we_cyc, vecs[i].we_addr, vecs[i].we_data,
              vecs[i].exp_issued, vecs[i].exp_early);
    end

    // Reset asserted mid-RUN, between clock edges.
    start    = 1'b1;
    prog_len = 4'd6;
    step();
    start = 1'b0;
    check("rst_pre", 1, 32'(act), 32'(expect_at(1, 6, 1'b0)));
    step();
    check("rst_pre", 2, 32'(act), 32'(expect_at(2, 6, 1'b0)));
    step();
    check("rst_pre", 3, 32'(act), 32'(expect_at(3, 6, 1'b0)));
    #2 rst = 1'b1;
    #1;
    check("rst_async", 3, 32'(act), 32'(0));
    step();
    check("rst_held", 0, 32'(act), 32'(0));
    rst = 1'b0;
    step();
    check("rst_idle", 0, 32'(act), 32'(0));
    run_vec("post_rst", 3, 0, 0, -1, 0, 16'h0000, 3, 0);

    // Randomized runs.
    for (int r = 0; r < 40; r++) begin
      int len;
      int nn;
      int ab;
      int az;
      int wc;
      write_slot(int'($urandom_range(0, 7)), 16'($urandom));
      write_slot(int'($urandom_range(0, 7)), 16'($urandom));
      len = int'($urandom_range(0, 15));
      nn  = (len > 8) ? 8 : len;
      ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : 0;
      az  = (nn >= 2 && $urandom_range(0, 2) == 0) ? int'($urandom_range(2, nn)) : 0;
      wc  = int'($urandom_range(0, nn + 4)) - 1;
      run_vec("random", len, ab, az, wc, int'($urandom_range(0, 7)),
              16'($urandom), -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
